// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: reset PC, NOP encoding, PC step, FSM states, payload type.
`ifndef FETCH_STAGE_PKG_SV
`define FETCH_STAGE_PKG_SV
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEF_NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP       = 32'd4;

  // Fetch FSM encodings
  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  // Instruction word plus the PC it was fetched from
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;

endpackage
`endif

// File: rtl/fetch_stage_if.sv
// Instruction memory read port between the fetch stage and instruction memory.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a new instruction, flush to a NOP bubble, or hold.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  fetch_pkt_t      load_pkt,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc
);

  // Reset dominates flush, flush dominates load; otherwise contents are held
  always_ff @(posedge clock) begin
    if (reset) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      id_pc    <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
    end else if (load) begin
      id_valid <= 1'b1;
      id_instr <= load_pkt.instr;
      id_pc    <= load_pkt.pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, FETCH/HOLD FSM, one-entry skid buffer, IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [XLEN-1:0]      redirect_pc,
  fetch_stage_if.master        imem,
  output logic                 id_valid,
  output logic [XLEN-1:0]      id_instr,
  output logic [XLEN-1:0]      id_pc,
  output logic [6:0]           id_opcode,
  output logic [2:0]           id_funct3,
  output logic [6:0]           id_funct7
);

  logic [0:0]      state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  fetch_pkt_t      skid, skid_nxt;
  logic            id_load, id_flush;
  fetch_pkt_t      id_pkt;
  logic            id_free;

  assign id_free        = !stall || !id_valid;
  assign imem.imem_req  = (state == ST_FETCH) && !reset;
  assign imem.imem_addr = pc;

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state <= ST_FETCH;
    else       state <= state_nxt;
  end

  // PC and skid buffer registers; reset drops any buffered or in-flight word
  always_ff @(posedge clock) begin
    if (reset) begin
      pc   <= RESET_PC;
      skid <= '0;
    end else begin
      pc   <= pc_nxt;
      skid <= skid_nxt;
    end
  end

  // Next-state, PC update and IF/ID control; redirect overrides everything
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    skid_nxt     = skid;
    id_load      = 1'b0;
    id_flush     = 1'b0;
    id_pkt.instr = imem.imem_rdata;
    id_pkt.pc    = pc;

    if (redirect) begin
      pc_nxt    = redirect_pc;
      id_flush  = 1'b1;
      state_nxt = ST_FETCH;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem.imem_ready) begin
            pc_nxt = XLEN'(pc + PC_STEP);
            if (id_free) begin
              id_load = 1'b1;
            end else begin
              skid_nxt.instr = imem.imem_rdata;
              skid_nxt.pc    = pc;
              state_nxt      = ST_HOLD;
            end
          end else if (!stall) begin
            id_flush = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            id_load   = 1'b1;
            id_pkt    = skid;
            state_nxt = ST_FETCH;
          end
        end
        default: state_nxt = ST_FETCH;
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clock    (clock),
    .reset    (reset),
    .load     (id_load),
    .flush    (id_flush),
    .load_pkt (id_pkt),
    .id_valid (id_valid),
    .id_instr (id_instr),
    .id_pc    (id_pc)
  );

  // Decoder fields are plain slices of the IF/ID instruction
  assign id_opcode = id_instr[6:0];
  assign id_funct3 = id_instr[14:12];
  assign id_funct7 = id_instr[31:25];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with an address-derived zero-wait memory model.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;

  int n_chk;
  int n_pass;

  fetch_stage_if imem ();

  fetch_stage dut (
    .clock       (clock),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem.master),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_opcode   (id_opcode),
    .id_funct3   (id_funct3),
    .id_funct7   (id_funct7)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a << 8) ^ 32'h5A00_70B3;
  endfunction

  // Memory returns a word derived from the presented address
  always_comb imem.imem_rdata = instr_of(imem.imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Check the full IF/ID register and fetch port in one go
  task automatic check_state(input string tag, input logic req, input logic [31:0] addr,
                             input logic vld, input logic [31:0] ins, input logic [31:0] pcv);
    check({tag, ".req"},   32'(imem.imem_req), 32'(req));
    check({tag, ".addr"},  imem.imem_addr, addr);
    check({tag, ".valid"}, 32'(id_valid), 32'(vld));
    check({tag, ".instr"}, id_instr, ins);
    if (vld) check({tag, ".id_pc"}, id_pc, pcv);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    imem.imem_ready = 1'b1;

    // Reset state
    tick();
    check("rst.req", 32'(imem.imem_req), 32'd0);
    check_state("rst", 1'b0, 32'h0, 1'b0, 32'h13, 32'h0);
    check("rst.id_pc", id_pc, 32'h0);
    reset = 1'b0;
    #1;
    check("post_rst.req", 32'(imem.imem_req), 32'd1);

    // Streaming with zero-wait memory
    tick(); check_state("s0", 1'b1, 32'h4, 1'b1, instr_of(32'h0), 32'h0);
    tick(); check_state("s4", 1'b1, 32'h8, 1'b1, instr_of(32'h4), 32'h4);

    // Memory wait for 3 cycles at address 8 produces bubbles
    imem.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); check_state("wait", 1'b1, 32'h8, 1'b0, 32'h13, 32'h0);
    end
    imem.imem_ready = 1'b1;
    tick(); check_state("w8", 1'b1, 32'hC, 1'b1, instr_of(32'h8), 32'h8);
    check("w8.opcode", 32'(id_opcode), 32'(instr_of(32'h8) & 32'h7F));
    check("w8.funct3", 32'(id_funct3), 32'((instr_of(32'h8) >> 12) & 32'h7));
    check("w8.funct7", 32'(id_funct7), 32'(instr_of(32'h8) >> 25));
    tick(); check_state("sC", 1'b1, 32'h10, 1'b1, instr_of(32'hC), 32'hC);

    // Stall while the word at 0x10 returns: skid into HOLD
    stall = 1'b1;
    tick(); check_state("hold1", 1'b0, 32'h14, 1'b1, instr_of(32'hC), 32'hC);
    tick(); check_state("hold2", 1'b0, 32'h14, 1'b1, instr_of(32'hC), 32'hC);
    stall = 1'b0;
    tick(); check_state("unhold", 1'b1, 32'h14, 1'b1, instr_of(32'h10), 32'h10);
    tick(); check_state("s14", 1'b1, 32'h18, 1'b1, instr_of(32'h14), 32'h14);
    tick(); check_state("s18", 1'b1, 32'h1C, 1'b1, instr_of(32'h18), 32'h18);
    tick(); check_state("s1C", 1'b1, 32'h20, 1'b1, instr_of(32'h1C), 32'h1C);

    // Redirect concurrent with a response at 0x20 drops that response
    redirect = 1'b1; redirect_pc = 32'h100;
    tick(); check_state("redir", 1'b1, 32'h100, 1'b0, 32'h13, 32'h0);
    redirect = 1'b0;
    tick(); check_state("s100", 1'b1, 32'h104, 1'b1, instr_of(32'h100), 32'h100);

    // Redirect with stall while in HOLD discards the buffered word
    stall = 1'b1;
    tick(); check_state("hold104", 1'b0, 32'h108, 1'b1, instr_of(32'h100), 32'h100);
    redirect = 1'b1; redirect_pc = 32'h200;
    tick(); check_state("redir_hold", 1'b1, 32'h200, 1'b0, 32'h13, 32'h0);
    redirect = 1'b0; stall = 1'b0;
    tick(); check_state("s200", 1'b1, 32'h204, 1'b1, instr_of(32'h200), 32'h200);

    // Reach HOLD with pc at the top of the address space, then reset
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF4;
    tick(); check_state("redir_top", 1'b1, 32'hFFFF_FFF4, 1'b0, 32'h13, 32'h0);
    redirect = 1'b0;
    tick(); check_state("sFFF4", 1'b1, 32'hFFFF_FFF8, 1'b1, instr_of(32'hFFFF_FFF4), 32'hFFFF_FFF4);
    stall = 1'b1;
    tick(); check_state("holdtop", 1'b0, 32'hFFFF_FFFC, 1'b1, instr_of(32'hFFFF_FFF4), 32'hFFFF_FFF4);
    reset = 1'b1;
    tick(); check_state("rst_hold", 1'b0, 32'h0, 1'b0, 32'h13, 32'h0);
    check("rst_hold.id_pc", id_pc, 32'h0);
    reset = 1'b0; stall = 1'b0;
    tick(); check_state("after_rst", 1'b1, 32'h4, 1'b1, instr_of(32'h0), 32'h0);

    // Reset mid-wait drops the pending fetch
    imem.imem_ready = 1'b0;
    tick(); check_state("wait4", 1'b1, 32'h4, 1'b0, 32'h13, 32'h0);
    reset = 1'b1;
    tick(); check_state("rst_wait", 1'b0, 32'h0, 1'b0, 32'h13, 32'h0);
    reset = 1'b0; imem.imem_ready = 1'b1;

    // PC wraps modulo 2^32 on a transfer at 0xFFFF_FFFC
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick(); check_state("redir_wrap", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h13, 32'h0);
    redirect = 1'b0;
    tick(); check_state("wrap", 1'b1, 32'h0, 1'b1, instr_of(32'hFFFF_FFFC), 32'hFFFF_FFFC);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0): ID instruction value when invalid or reset.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hazard request to hold the IF/ID register.
REQ-006 redirect  input  1  branch/jump taken; flush and refetch.
REQ-007 redirect_pc  input  32  target PC, sampled when redirect=1.
REQ-008 imem_req  output  1  instruction memory read request.
REQ-009 imem_addr  output  32  fetch address (current PC).
REQ-010 imem_ready  input  1  read data valid this cycle for imem_addr.
REQ-011 imem_rdata  input  32  instruction word.
REQ-012 id_valid  output  1  IF/ID register holds a real instruction.
REQ-013 id_instr  output  32  registered instruction.
REQ-014 id_pc  output  32  PC of id_instr.
REQ-015 id_opcode, id_funct3, id_funct7  output  7/3/7  id_instr[6:0], [14:12], [31:25]; drive the control decoder directly.

Function
REQ-016 The block SHALL implement states FETCH and HOLD; reset state FETCH.
REQ-017 imem_req SHALL be 1 in FETCH and 0 in HOLD, and 0 whenever reset=1; imem_addr SHALL equal pc.
REQ-018 Transfer = FETCH, imem_ready=1, redirect=0; "ID free" = (stall=0 or id_valid=0).
REQ-019 Transfer with ID free: id_instr<=imem_rdata, id_pc<=pc, id_valid<=1, pc<=pc+4 (modulo 2^32); stay FETCH; one-instruction-per-cycle throughput with a zero-wait memory.
REQ-020 Transfer with ID not free: capture imem_rdata and pc into a one-entry buffer, pc<=pc+4, go HOLD; ID register unchanged.
REQ-021 HOLD with stall=0: move buffer to ID (id_valid<=1), go FETCH.
REQ-022 HOLD with stall=1: all state held.
REQ-023 FETCH with imem_ready=0 and no redirect: pc unchanged; if ID free and stall=0, id_valid<=0 (bubble), id_instr<=NOP_INSTR.
REQ-024 stall=1 with id_valid=1 SHALL hold id_instr/id_pc/id_valid unchanged.
REQ-025 redirect=1 has highest priority over stall and imem_ready in any state: pc<=redirect_pc, id_valid<=0, id_instr<=NOP_INSTR, buffer discarded, state<=FETCH; a response arriving the same cycle SHALL be dropped.
REQ-026 imem_addr MAY change while imem_req=1 and imem_ready=0 only as a result of redirect; the memory returns data for the address presented in the ready cycle.
REQ-027 id_opcode/funct3/funct7 SHALL be pure slices of id_instr with no extra latency.
REQ-028 Latency: first instruction valid in ID one cycle after the first imem_ready=1 cycle.

Reset
REQ-029 On reset=1 at a clock edge: pc<=RESET_PC, state<=FETCH, id_valid<=0, id_instr<=NOP_INSTR, id_pc<=0, buffer cleared; reset dominates redirect, stall and imem_ready.
REQ-030 Reset asserted mid-HOLD or mid-wait SHALL discard buffered and in-flight data.

Structure
REQ-031 RESET_PC default, NOP_INSTR, PC step (4) and state encodings SHALL live in the shared processor definitions include, guarded like the other shared headers.
REQ-032 The IF/ID register SHALL be a separate sub-module if_id_reg (load, flush, hold); PC, FSM and buffer stay in fetch_stage.

Verification
REQ-033 Reset, imem_ready=1 constant, rdata=addr-derived -> imem_addr 0,4,8,C on successive cycles; id_pc 0,4,8 lagging one cycle; id_valid=1 from cycle 2.
REQ-034 imem_ready low 3 cycles at addr 8 -> imem_addr holds 8, id_valid=0 for 3 cycles, then id_pc=8, id_instr=rdata.
REQ-035 stall=1 for 2 cycles while instruction at 0x10 returns -> HOLD entered, imem_req=0, ID holds 0xC; stall drop -> id_pc=0x10 next cycle, fetch resumes at 0x14.
REQ-036 redirect=1, redirect_pc=0x100 concurrent with imem_ready=1 at 0x20 -> response dropped, id_valid=0 next cycle, imem_addr=0x100, next id_pc=0x100.
REQ-037 redirect=1 and stall=1 in HOLD -> buffer discarded, id_valid=0, state FETCH at redirect_pc.
REQ-038 reset asserted in HOLD with pc=0xFFFF_FFFC -> pc=RESET_PC, id_valid=0, id_instr=0x13; separately pc=0xFFFF_FFFC + transfer wraps pc to 0.
